rf_wb_arbiter: RTL

Write-port arbiter and pending-write scoreboard for the 32x32 register file. It shares the file's single write port between the in-order pipeline writeback stage and a long-latency unit (mul/div, load-miss return) that uses a valid/ready handshake. It tracks which destination registers have long-latency writes outstanding, so decode can stall on RAW/WAW hazards. It sits between the writeback sources and the register file's we/rd/wd inputs.

---
 rtl/rf_wb_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline writeback and a long-latency unit, and tracks pending long writes.
// Define RF_WB_ARB_STARVE_GUARD_EN to add the starvation counter and the FORCE_LU state.
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [$clog2(NREG)-1:0]  pipe_rd,
  input  logic [XLEN-1:0]          pipe_wd,
  output logic                     pipe_stall,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [$clog2(NREG)-1:0]  lu_rd,
  input  logic [XLEN-1:0]          lu_wd,
  input  logic                     issue_lu,
  input  logic [$clog2(NREG)-1:0]  issue_rd,
  input  logic [$clog2(NREG)-1:0]  chk_rs1,
  input  logic [$clog2(NREG)-1:0]  chk_rs2,
  input  logic [$clog2(NREG)-1:0]  chk_rd,
  output logic                     hazard,
  output logic [NREG-1:0]          busy,
  output logic                     rf_we,
  output logic [$clog2(NREG)-1:0]  rf_rd,
  output logic [XLEN-1:0]          rf_wd
);
  localparam int IW = $clog2(NREG);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end
  logic            force_lu;
  logic            hs;
  logic            pipe_go;
  logic [IW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_wd;
  logic [NREG-1:0] busy_nxt;
`ifdef RF_WB_ARB_STARVE_GUARD_EN
  typedef enum logic {PIPE_PRI, FORCE_LU} state_t;
  state_t   state;
  logic [3:0] cnt;
  assign force_lu = state == FORCE_LU;
  // In FORCE_LU lu_ready follows lu_valid, so lu_valid alone marks the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PIPE_PRI;
      cnt <= '0;
    end else if (force_lu) begin
      cnt <= '0;
      if (lu_valid) state <= PIPE_PRI;
    end else if (!lu_valid || lu_ready) begin
      cnt <= '0;
    end else if (cnt == 4'(STARVE_LIMIT - 1)) begin
      cnt <= '0;
      state <= FORCE_LU;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end
`else
  assign force_lu = 1'b0;
`endif
  assign pipe_stall = force_lu;
  assign lu_ready = !rst && lu_valid && (force_lu || !pipe_we);
  assign hs = lu_valid && lu_ready;
  assign pipe_go = pipe_we && !force_lu;
  assign wr_rd = hs ? lu_rd : pipe_rd;
  assign wr_wd = hs ? lu_wd : pipe_wd;
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= (hs || pipe_go) && wr_rd != '0;
      if (hs || pipe_go) begin
        rf_rd <= wr_rd;
        rf_wd <= wr_wd;
      end
    end
  end
  // Set is applied after clear so a same-cycle issue to the returning register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (hs) busy_nxt[lu_rd] = 1'b0;
    if (issue_lu) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) busy <= rst ? '0 : busy_nxt;
  assign hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];
endmodule
